// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the waveform NCO and the SPI DAC transmitter.
// The NCO side drives sample_in/sample_valid; the transmitter answers with
// sample_ready.
interface dac_spi_tx_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/dac_spi_tx.sv
// SPI DAC transmitter: serialises one 8-bit NCO sample per frame as
// {CMD, sample, 4'b0000}, MSB first, SPI mode 0 (SCLK idles low, data is
// stable across the rising edge). The frame runs IDLE -> SHIFT -> GAP -> IDLE.
// CLK_DIV and GAP_CYCLES must both be at least 1.
module dac_spi_tx #(
  parameter int          CLK_DIV    = 2,
  parameter logic [3:0]  CMD        = 4'h3,
  parameter int          GAP_CYCLES = 2
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  dac_spi_tx_if.slave        smp,
  output logic               dac_sclk,
  output logic               dac_cs_n,
  output logic               dac_mosi,
  output logic               busy,
  output logic               frame_done
);

  // Counter widths are clamped to one bit so CLK_DIV=1 / GAP_CYCLES=1 still
  // give legal vectors.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [15:0]      shreg_r, shreg_s;
  logic [3:0]       bit_r, bit_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic             sclk_r, sclk_s;
  logic             cs_n_r, cs_n_s;
  logic             mosi_r, mosi_s;
  logic             busy_r, busy_s;
  logic             frame_done_r, frame_done_s;

  // Ready is a pure decode of the registered state, never of sample_valid.
  assign smp.sample_ready = (state_r == ST_IDLE);

  assign dac_sclk   = sclk_r;
  assign dac_cs_n   = cs_n_r;
  assign dac_mosi   = mosi_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    bit_s        = bit_r;
    div_s        = div_r;
    gap_s        = gap_r;
    sclk_s       = sclk_r;
    cs_n_s       = cs_n_r;
    mosi_s       = mosi_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (smp.sample_valid) begin
          // Capture the whole frame now; later input changes cannot leak in.
          state_s = ST_SHIFT;
          shreg_s = {CMD, smp.sample_in, 4'b0000};
          bit_s   = 4'd15;
          div_s   = {DIV_W{1'b0}};
          sclk_s  = 1'b0;
          cs_n_s  = 1'b0;
          mosi_s  = CMD[3];
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_s = {DIV_W{1'b0}};
          if (!sclk_r) begin
            // End of low phase: rising edge, DAC samples the current bit.
            sclk_s = 1'b1;
          end else if (bit_r == 4'd0) begin
            // End of the 16th high phase: close the frame.
            state_s      = ST_GAP;
            gap_s        = {GAP_W{1'b0}};
            sclk_s       = 1'b0;
            cs_n_s       = 1'b1;
            mosi_s       = 1'b0;
            frame_done_s = 1'b1;
          end else begin
            // End of high phase: falling edge, present the next bit.
            bit_s   = bit_r - 4'd1;
            sclk_s  = 1'b0;
            mosi_s  = shreg_r[14];
            shreg_s = {shreg_r[14:0], 1'b0};
          end
        end else begin
          div_s = div_r + DIV_ONE;
        end
      end

      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_IDLE;
          gap_s   = {GAP_W{1'b0}};
          busy_s  = 1'b0;
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        shreg_s = 16'h0000;
        bit_s   = 4'd0;
        div_s   = {DIV_W{1'b0}};
        gap_s   = {GAP_W{1'b0}};
        sclk_s  = 1'b0;
        cs_n_s  = 1'b1;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drives CS_n high immediately.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      shreg_r      <= 16'h0000;
      bit_r        <= 4'd0;
      div_r        <= {DIV_W{1'b0}};
      gap_r        <= {GAP_W{1'b0}};
      sclk_r       <= 1'b0;
      cs_n_r       <= 1'b1;
      mosi_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      bit_r        <= bit_s;
      div_r        <= div_s;
      gap_r        <= gap_s;
      sclk_r       <= sclk_s;
      cs_n_r       <= cs_n_s;
      mosi_r       <= mosi_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default instance (CLK_DIV=2, GAP=2) and a fast
// instance (CLK_DIV=1, GAP=1) run side by side against a cycle-offset model.
module tb_dac_spi_tx;

  logic clk_50MHz = 1'b0;
  logic reset;

  always #10 clk_50MHz = ~clk_50MHz;

  dac_spi_tx_if if0();
  dac_spi_tx_if if1();

  logic sclk0, cs0, mosi0, busy0, fd0;
  logic sclk1, cs1, mosi1, busy1, fd1;

  dac_spi_tx u0 (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .smp       (if0),
    .dac_sclk  (sclk0),
    .dac_cs_n  (cs0),
    .dac_mosi  (mosi0),
    .busy      (busy0),
    .frame_done(fd0)
  );

  dac_spi_tx #(.CLK_DIV(1), .CMD(4'h3), .GAP_CYCLES(1)) u1 (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .smp       (if1),
    .dac_sclk  (sclk1),
    .dac_cs_n  (cs1),
    .dac_mosi  (mosi1),
    .busy      (busy1),
    .frame_done(fd1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Bits seen by the DAC on each SCLK rising edge.
  logic [15:0] cap0 = 16'h0000, cap1 = 16'h0000;
  int edges0 = 0, edges1 = 0;

  always @(posedge sclk0) begin
    cap0 = {cap0[14:0], mosi0};
    edges0++;
  end

  always @(posedge sclk1) begin
    cap1 = {cap1[14:0], mosi1};
    edges1++;
  end

  // Reference model: outputs follow from the offset k since the accept cycle.
  int          cyc = 0;
  int          tacc[2] = '{-100000, -100000};
  logic [15:0] frm[2];
  int          cdv[2] = '{2, 1};
  int          gpv[2] = '{2, 1};

  always @(negedge clk_50MHz) begin
    logic [5:0] got, exp_v;
    logic       vld;
    logic [7:0] smpv;
    int         len, k, p, b;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        got  = {cs0, sclk0, mosi0, busy0, fd0, if0.sample_ready};
        vld  = if0.sample_valid;
        smpv = if0.sample_in;
      end else begin
        got  = {cs1, sclk1, mosi1, busy1, fd1, if1.sample_ready};
        vld  = if1.sample_valid;
        smpv = if1.sample_in;
      end
      if (!reset) begin
        exp_v   = 6'b100001;
        tacc[i] = -100000;
      end else begin
        len = 32 * cdv[i];
        k   = cyc - tacc[i];
        if (k >= 1 && k <= len) begin
          p = k - 1;
          b = p / (2 * cdv[i]);
          exp_v[5] = 1'b0;
          exp_v[4] = ((p % (2 * cdv[i])) >= cdv[i]);
          exp_v[3] = frm[i][15 - b];
        end else begin
          exp_v[5:3] = 3'b100;
        end
        exp_v[2] = (k >= 1 && k <= len + gpv[i]);
        exp_v[1] = (k == len + 1);
        exp_v[0] = !exp_v[2];
        if (exp_v[0] && vld) begin
          tacc[i] = cyc;
          frm[i]  = {4'h3, smpv, 4'h0};
        end
      end
      chk($sformatf("dut%0d_outputs_cyc%0d", i, cyc), {26'd0, got}, {26'd0, exp_v});
    end
  end

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, cslow0, cslow1, fdoff0, fdoff1, rdy0, rdy1;
    int acc0[$];
    int acc1[$];

    // Reset state
    reset = 1'b0;
    if0.sample_valid = 1'b0; if0.sample_in = 8'h00;
    if1.sample_valid = 1'b0; if1.sample_in = 8'h00;
    repeat (3) @(posedge clk_50MHz);
    #1;
    chk("rst_cs0",    {31'd0, cs0},   32'd1);
    chk("rst_sclk0",  {31'd0, sclk0}, 32'd0);
    chk("rst_mosi0",  {31'd0, mosi0}, 32'd0);
    chk("rst_ready0", {31'd0, if0.sample_ready}, 32'd1);
    chk("rst_busy0",  {31'd0, busy0}, 32'd0);
    chk("rst_fd0",    {31'd0, fd0},   32'd0);
    chk("rst_cs1",    {31'd0, cs1},   32'd1);
    reset = 1'b1;

    // Long idle: no activity at all
    e0 = edges0; e1 = edges1;
    repeat (200) tick();
    chk("idle_edges0", edges0 - e0, 32'd0);
    chk("idle_edges1", edges1 - e1, 32'd0);
    chk("idle_cs0",    {31'd0, cs0},   32'd1);
    chk("idle_busy0",  {31'd0, busy0}, 32'd0);

    // Single frames: 0xA5 on default, 0xFF on fast instance
    e0 = edges0; e1 = edges1;
    if0.sample_valid = 1'b1; if0.sample_in = 8'hA5;
    if1.sample_valid = 1'b1; if1.sample_in = 8'hFF;
    tick();
    if0.sample_valid = 1'b0; if1.sample_valid = 1'b0;
    cslow0 = 0; cslow1 = 0; fdoff0 = -1; fdoff1 = -1; rdy0 = -1; rdy1 = -1;
    for (int n = 1; n <= 150 && (rdy0 < 0 || rdy1 < 0); n++) begin
      @(negedge clk_50MHz);
      if (!cs0) cslow0++;
      if (!cs1) cslow1++;
      if (fd0 && fdoff0 < 0) fdoff0 = n;
      if (fd1 && fdoff1 < 0) fdoff1 = n;
      if (if0.sample_ready && rdy0 < 0) rdy0 = n;
      if (if1.sample_ready && rdy1 < 0) rdy1 = n;
    end
    chk("a5_bits",    {16'd0, cap0}, 32'h3A50);
    chk("a5_edges",   edges0 - e0,   32'd16);
    chk("a5_cs_low",  cslow0,        32'd64);
    chk("a5_fd_at",   fdoff0,        32'd65);
    chk("a5_ready_at", rdy0,         32'd67);
    chk("ff_bits",    {16'd0, cap1}, 32'h3FF0);
    chk("ff_edges",   edges1 - e1,   32'd16);
    chk("ff_cs_low",  cslow1,        32'd32);
    chk("ff_fd_at",   fdoff1,        32'd33);
    chk("ff_ready_at", rdy1,         32'd34);

    // Continuous valid with ramping / random samples
    tick();
    if0.sample_valid = 1'b1; if1.sample_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_50MHz);
      if (if0.sample_ready) acc0.push_back(n);
      if (if1.sample_ready) acc1.push_back(n);
      @(posedge clk_50MHz);
      #1;
      if0.sample_in = if0.sample_in + 8'd1;
      if1.sample_in = 8'($urandom);
    end
    if0.sample_valid = 1'b0; if1.sample_valid = 1'b0;
    chk("cont_accepts0", acc0.size(), 32'd5);
    chk("cont_accepts1", acc1.size(), 32'd9);
    for (int j = 1; j < acc0.size(); j++) chk("cont_period0", acc0[j] - acc0[j-1], 32'd67);
    for (int j = 1; j < acc1.size(); j++) chk("cont_period1", acc1[j] - acc1[j-1], 32'd34);
    repeat (80) tick();

    // Random valid and data
    for (int n = 0; n < 1500; n++) begin
      if0.sample_valid = ($urandom_range(0, 3) == 0);
      if0.sample_in    = 8'($urandom);
      if1.sample_valid = ($urandom_range(0, 3) == 0);
      if1.sample_in    = 8'($urandom);
      tick();
    end
    if0.sample_valid = 1'b0; if1.sample_valid = 1'b0;
    repeat (80) tick();

    // Reset in the middle of bit 7, then a clean 0x3C frame
    if0.sample_valid = 1'b1; if0.sample_in = 8'h5A;
    tick();
    if0.sample_valid = 1'b0;
    repeat (33) @(posedge clk_50MHz);
    #3;
    chk("mid_cs_low", {31'd0, cs0}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_cs",   {31'd0, cs0},   32'd1);
    chk("mid_rst_sclk", {31'd0, sclk0}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    repeat (3) @(posedge clk_50MHz);
    #1;
    reset = 1'b1;
    tick();
    e0 = edges0;
    if0.sample_valid = 1'b1; if0.sample_in = 8'h3C;
    tick();
    if0.sample_valid = 1'b0;
    fdoff0 = -1;
    for (int n = 1; n <= 150 && fdoff0 < 0; n++) begin
      @(negedge clk_50MHz);
      if (fd0) fdoff0 = n;
    end
    chk("r3c_fd_at", fdoff0,        32'd65);
    chk("r3c_bits",  {16'd0, cap0}, 32'h33C0);
    chk("r3c_edges", edges0 - e0,   32'd16);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
